// File: rtl/fb_cmd_writer.sv
// Framebuffer port-A write master: turns the SPI command byte stream into pixel writes,
// palette writes, hardware fills and vblank waits.
module fb_cmd_writer #(
  parameter int FB_SIZE = 76800,
  parameter int ADDR_W  = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [7:0]        cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              vblank_async,
  output logic [ADDR_W-1:0] rgb_addr,
  output logic [7:0]        rgb_in,
  output logic              wren_rgb,
  output logic [7:0]        palette_addr,
  output logic [23:0]       palette_in,
  output logic              wren_palette,
  output logic              busy,
  output logic              error
);
  typedef enum logic [3:0] {
    S_OPCODE, S_ADDR0, S_ADDR1, S_ADDR2, S_PIXELS, S_PAL_IDX, S_PAL_R, S_PAL_G,
    S_PAL_B, S_CNT0, S_CNT1, S_CNT2, S_FILL_VAL, S_FILLING, S_WAIT_VB, S_IGNORE
  } state_t;

  localparam logic [ADDR_W:0]   FB_LIM  = (ADDR_W+1)'(FB_SIZE);
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_SIZE - 1);

  state_t            state_q, st;
  logic [ADDR_W-1:0] addr_q, cnt_q, addr_inc, start_addr;
  logic [7:0]        pal_idx_q, pal_r_q, pal_g_q, fill_val_q;
  logic              is_fill_q, busy_q;
  logic [2:0]        vb_q;
  logic              vb_rise, accept, bad_addr;

  // cmd_start forces the opcode state in the same cycle so a concurrent byte is the new opcode
  assign st         = cmd_start ? S_OPCODE : state_q;
  assign cmd_ready  = ~busy_q;
  assign busy       = busy_q;
  assign accept     = cmd_valid & ~busy_q;
  assign vb_rise    = vb_q[1] & ~vb_q[2];
  assign addr_inc   = (addr_q == FB_LAST) ? '0 : addr_q + 1'b1;
  assign start_addr = {addr_q[ADDR_W-1:8], cmd_data};
  assign bad_addr   = {1'b0, start_addr} >= FB_LIM;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_OPCODE;   busy_q <= 1'b0;     error <= 1'b0;
      addr_q <= '0;          cnt_q <= '0;        is_fill_q <= 1'b0;
      pal_idx_q <= '0;       pal_r_q <= '0;      pal_g_q <= '0;
      fill_val_q <= '0;      vb_q <= '0;
      rgb_addr <= '0;        rgb_in <= '0;       wren_rgb <= 1'b0;
      palette_addr <= '0;    palette_in <= '0;   wren_palette <= 1'b0;
    end else begin
      vb_q         <= {vb_q[1:0], vblank_async};
      wren_rgb     <= 1'b0;
      wren_palette <= 1'b0;
      busy_q       <= 1'b0;
      state_q      <= st;
      case (st)
        S_OPCODE: if (accept) begin
          case (cmd_data)
            8'h01:   begin is_fill_q <= 1'b0; state_q <= S_ADDR0; end
            8'h02:   state_q <= S_PAL_IDX;
            8'h03:   begin is_fill_q <= 1'b1; state_q <= S_ADDR0; end
            8'h04:   begin busy_q <= 1'b1; state_q <= S_WAIT_VB; end
            default: begin error <= 1'b1; state_q <= S_IGNORE; end
          endcase
        end
        S_ADDR0: if (accept) begin
          addr_q[ADDR_W-1:16] <= cmd_data[ADDR_W-17:0];
          state_q <= S_ADDR1;
        end
        S_ADDR1: if (accept) begin
          addr_q[15:8] <= cmd_data;
          state_q <= S_ADDR2;
        end
        S_ADDR2: if (accept) begin
          if (bad_addr) begin
            error   <= 1'b1;
            state_q <= S_IGNORE;
          end else begin
            addr_q  <= start_addr;
            state_q <= is_fill_q ? S_CNT0 : S_PIXELS;
          end
        end
        S_PIXELS: if (accept) begin
          wren_rgb <= 1'b1; rgb_addr <= addr_q; rgb_in <= cmd_data;
          addr_q   <= addr_inc;
        end
        S_PAL_IDX: if (accept) begin pal_idx_q <= cmd_data; state_q <= S_PAL_R; end
        S_PAL_R:   if (accept) begin pal_r_q <= cmd_data;   state_q <= S_PAL_G; end
        S_PAL_G:   if (accept) begin pal_g_q <= cmd_data;   state_q <= S_PAL_B; end
        S_PAL_B: if (accept) begin
          wren_palette <= 1'b1;
          palette_addr <= pal_idx_q;
          palette_in   <= {pal_r_q, pal_g_q, cmd_data};
          pal_idx_q    <= pal_idx_q + 8'd1;
          state_q      <= S_PAL_R;
        end
        S_CNT0: if (accept) begin cnt_q[ADDR_W-1:16] <= cmd_data[ADDR_W-17:0]; state_q <= S_CNT1; end
        S_CNT1: if (accept) begin cnt_q[15:8] <= cmd_data; state_q <= S_CNT2; end
        S_CNT2: if (accept) begin cnt_q[7:0]  <= cmd_data; state_q <= S_FILL_VAL; end
        S_FILL_VAL: if (accept) begin
          fill_val_q <= cmd_data;
          if (cnt_q != '0) begin
            // first write is issued here so wren_rgb follows V by one cycle
            wren_rgb <= 1'b1; rgb_addr <= addr_q; rgb_in <= cmd_data;
            addr_q   <= addr_inc;
            cnt_q    <= cnt_q - 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_FILLING;
          end else begin
            state_q  <= S_OPCODE;
          end
        end
        S_FILLING: begin
          if (cnt_q != '0) begin
            wren_rgb <= 1'b1; rgb_addr <= addr_q; rgb_in <= fill_val_q;
            addr_q   <= addr_inc;
            cnt_q    <= cnt_q - 1'b1;
            busy_q   <= 1'b1;
          end else begin
            // stay one extra cycle so busy covers the final strobe
            state_q  <= S_OPCODE;
          end
        end
        S_WAIT_VB: begin
          if (vb_rise) state_q <= S_OPCODE;
          else         busy_q  <= 1'b1;
        end
        S_IGNORE: state_q <= S_IGNORE;
        default:  state_q <= S_OPCODE;
      endcase
    end
  end
endmodule
